// File: rtl/exec_pkg.sv
// Shared definitions for the RV32 execute unit: opcodes, FSM states and
// special-result constants. EXEC_UNIT_MDU_EN enables the iterative M extension.
package exec_pkg;

    localparam int unsigned OP_W     = 5;
    localparam int unsigned MAX_XLEN = 64;

    localparam logic [OP_W-1:0] OP_AND    = 5'h00;
    localparam logic [OP_W-1:0] OP_OR     = 5'h01;
    localparam logic [OP_W-1:0] OP_ADD    = 5'h02;
    localparam logic [OP_W-1:0] OP_XOR    = 5'h03;
    localparam logic [OP_W-1:0] OP_SUB    = 5'h06;
    localparam logic [OP_W-1:0] OP_SLT    = 5'h07;
    localparam logic [OP_W-1:0] OP_SLL    = 5'h08;
    localparam logic [OP_W-1:0] OP_SRL    = 5'h09;
    localparam logic [OP_W-1:0] OP_SRA    = 5'h0A;
    localparam logic [OP_W-1:0] OP_SLTU   = 5'h0B;
    localparam logic [OP_W-1:0] OP_PASSA  = 5'h0C;
    localparam logic [OP_W-1:0] OP_PASSB  = 5'h0D;
    localparam logic [OP_W-1:0] OP_MUL    = 5'h10;
    localparam logic [OP_W-1:0] OP_MULH   = 5'h11;
    localparam logic [OP_W-1:0] OP_MULHSU = 5'h12;
    localparam logic [OP_W-1:0] OP_MULHU  = 5'h13;
    localparam logic [OP_W-1:0] OP_DIV    = 5'h14;
    localparam logic [OP_W-1:0] OP_DIVU   = 5'h15;
    localparam logic [OP_W-1:0] OP_REM    = 5'h16;
    localparam logic [OP_W-1:0] OP_REMU   = 5'h17;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    // Special results, sized for the widest supported XLEN and truncated by users.
    localparam logic [MAX_XLEN-1:0] ALL_ONES_MAX = '1;

    function automatic logic [MAX_XLEN-1:0] most_neg(input int unsigned xlen);
        return MAX_XLEN'(1) << (xlen - 1);
    endfunction

endpackage

// File: rtl/exec_mdu_iter.sv
// Iterative RV32M datapath: shared shift-add multiplier / restoring divider on
// operand magnitudes, with step counter, sign correction and special cases.
module exec_mdu_iter
    import exec_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            start,
    input  logic            step_en,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            last_c,
    output logic [XLEN-1:0] result_c
);

    localparam int unsigned CW = $clog2(XLEN);
    localparam int unsigned PW = 2 * XLEN;
    localparam logic [XLEN-1:0] ALL_ONES = XLEN'(ALL_ONES_MAX);
    localparam logic [XLEN-1:0] MOST_NEG = XLEN'(most_neg(XLEN));

    logic [PW-1:0]   p_q, p_d;
    logic [XLEN-1:0] opnd_q, opnd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic            sa_q, sa_d;
    logic            sb_q, sb_d;
    logic            dz_q, dz_d;
    logic            ovf_q, ovf_d;

    logic            is_mul;
    logic            a_sgn;
    logic            b_sgn;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic [XLEN:0]   add_sum;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   rem_diff;
    logic [PW-1:0]   prod;
    logic [XLEN-1:0] quot;
    logic [XLEN-1:0] rem;

    // Operand signedness by opcode: MUL/MULH both, MULHSU A only, DIV/REM both.
    always_comb begin
        is_mul = ~op[2];
        a_sgn  = a[XLEN-1] & (is_mul ? (op[1:0] != 2'b11) : ~op[0]);
        b_sgn  = b[XLEN-1] & (is_mul ? ~op[1] : ~op[0]);
        mag_a  = a_sgn ? -a : a;
        mag_b  = b_sgn ? -b : b;
    end

    // p_q holds {accumulator/remainder, multiplier/quotient}.
    always_comb begin
        add_sum  = {1'b0, p_q[PW-1:XLEN]} + (p_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh   = {p_q[PW-1:XLEN], p_q[XLEN-1]};
        rem_diff = rem_sh - {1'b0, opnd_q};
    end

    always_comb begin
        p_d    = p_q;
        opnd_d = opnd_q;
        cnt_d  = cnt_q;
        op_d   = op_q;
        sa_d   = sa_q;
        sb_d   = sb_q;
        dz_d   = dz_q;
        ovf_d  = ovf_q;
        if (clear) begin
            cnt_d = '0;
        end else if (start) begin
            op_d   = op;
            sa_d   = a_sgn;
            sb_d   = b_sgn;
            dz_d   = (b == '0);
            ovf_d  = op[2] & ~op[0] & (a == MOST_NEG) & (b == ALL_ONES);
            opnd_d = is_mul ? mag_a : mag_b;
            p_d    = {XLEN'(0), (is_mul ? mag_b : mag_a)};
            cnt_d  = CW'(XLEN - 1);
        end else if (step_en) begin
            if (~op_q[2]) begin
                p_d = {add_sum, p_q[XLEN-1:1]};
            end else if (~rem_diff[XLEN]) begin
                p_d = {rem_diff[XLEN-1:0], p_q[XLEN-2:0], 1'b1};
            end else begin
                p_d = {rem_sh[XLEN-1:0], p_q[XLEN-2:0], 1'b0};
            end
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q    <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
            op_q   <= '0;
            sa_q   <= 1'b0;
            sb_q   <= 1'b0;
            dz_q   <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            p_q    <= p_d;
            opnd_q <= opnd_d;
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            sa_q   <= sa_d;
            sb_q   <= sb_d;
            dz_q   <= dz_d;
            ovf_q  <= ovf_d;
        end
    end

    assign last_c = (cnt_q == '0);

    // Remainder-by-zero already yields A after sign correction; only quotients need overriding.
    always_comb begin
        prod = (sa_q ^ sb_q) ? -p_q : p_q;
        quot = (sa_q ^ sb_q) ? -p_q[XLEN-1:0] : p_q[XLEN-1:0];
        rem  = sa_q ? -p_q[PW-1:XLEN] : p_q[PW-1:XLEN];
        if (~op_q[2]) begin
            result_c = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[PW-1:XLEN];
        end else if (~op_q[1]) begin
            result_c = dz_q ? ALL_ONES : (ovf_q ? MOST_NEG : quot);
        end else begin
            result_c = ovf_q ? '0 : rem;
        end
    end

endmodule

// File: rtl/exec_unit.sv
// Handshaked RV32 execute unit: single-cycle base ALU plus, when EXEC_UNIT_MDU_EN
// is defined, an iterative fixed-latency multiply/divide path.
module exec_unit
    import exec_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    localparam int unsigned SHW = $clog2(XLEN);

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  out_result_q, out_result_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             out_illegal_q, out_illegal_d;

    logic             accept_c;
    logic [XLEN-1:0]  alu_res_c;
    logic             alu_ill_c;
    logic [SHW-1:0]   shamt;

    assign in_ready = rst_n && (state_q == ST_IDLE) && !flush && (!out_valid_q || out_ready);
    assign accept_c = in_valid && in_ready;

    // Base ALU; every opcode without a case arm (including all M ops) is illegal here.
    always_comb begin
        alu_res_c = '0;
        alu_ill_c = 1'b0;
        shamt     = in_b[SHW-1:0];
        case (in_op)
            OP_AND:   alu_res_c = in_a & in_b;
            OP_OR:    alu_res_c = in_a | in_b;
            OP_ADD:   alu_res_c = in_a + in_b;
            OP_XOR:   alu_res_c = in_a ^ in_b;
            OP_SUB:   alu_res_c = in_a - in_b;
            OP_SLT:   alu_res_c = XLEN'($signed(in_a) < $signed(in_b));
            OP_SLTU:  alu_res_c = XLEN'(in_a < in_b);
            OP_SLL:   alu_res_c = in_a << shamt;
            OP_SRL:   alu_res_c = in_a >> shamt;
            OP_SRA:   alu_res_c = $signed(in_a) >>> shamt;
            OP_PASSA: alu_res_c = in_a;
            OP_PASSB: alu_res_c = in_b;
            default:  alu_ill_c = 1'b1;
        endcase
    end

`ifdef EXEC_UNIT_MDU_EN
    logic             is_mop_c;
    logic             mdu_start_c;
    logic             mdu_last_c;
    logic [XLEN-1:0]  mdu_result_c;
    logic [TAG_W-1:0] tag_q, tag_d;

    assign is_mop_c    = in_op[4] & ~in_op[3];
    assign mdu_start_c = accept_c & is_mop_c;

    exec_mdu_iter #(
        .XLEN (XLEN)
    ) u_mdu (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (flush),
        .start    (mdu_start_c),
        .step_en  (state_q == ST_BUSY),
        .op       (in_op[2:0]),
        .a        (in_a),
        .b        (in_b),
        .last_c   (mdu_last_c),
        .result_c (mdu_result_c)
    );

    always_comb begin
        tag_d = mdu_start_c ? in_tag : tag_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= '0;
        end else begin
            tag_q <= tag_d;
        end
    end
`endif

    // Next state and output register; flush overrides both acceptance and completion.
    always_comb begin
        state_d       = state_q;
        out_valid_d   = out_valid_q;
        out_result_d  = out_result_q;
        out_tag_d     = out_tag_q;
        out_illegal_d = out_illegal_q;
        if (out_ready) begin
            out_valid_d   = 1'b0;
            out_result_d  = '0;
            out_tag_d     = '0;
            out_illegal_d = 1'b0;
        end
`ifdef EXEC_UNIT_MDU_EN
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    if (is_mop_c) begin
                        state_d = ST_BUSY;
                    end else begin
                        out_valid_d   = 1'b1;
                        out_result_d  = alu_res_c;
                        out_tag_d     = in_tag;
                        out_illegal_d = alu_ill_c;
                    end
                end
            end
            ST_BUSY: begin
                if (mdu_last_c) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                out_valid_d   = 1'b1;
                out_result_d  = mdu_result_c;
                out_tag_d     = tag_q;
                out_illegal_d = 1'b0;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
`else
        if (accept_c) begin
            out_valid_d   = 1'b1;
            out_result_d  = alu_res_c;
            out_tag_d     = in_tag;
            out_illegal_d = alu_ill_c;
        end
`endif
        if (flush) begin
            state_d       = ST_IDLE;
            out_valid_d   = 1'b0;
            out_result_d  = '0;
            out_tag_d     = '0;
            out_illegal_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_tag_q     <= '0;
            out_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_tag_q     <= out_tag_d;
            out_illegal_q <= out_illegal_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_tag     = out_tag_q;
    assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_exec_unit.sv
// Directed self-checking bench for exec_unit; expectations follow EXEC_UNIT_MDU_EN.
module tb_exec_unit;
    import exec_pkg::*;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned TAG_W = 5;
`ifdef EXEC_UNIT_MDU_EN
    localparam bit MDU = 1'b1;
`else
    localparam bit MDU = 1'b0;
`endif
    localparam int M_LAT = MDU ? XLEN + 2 : 1;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] res;
        logic        ill;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       in_op;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;

    int n_tests = 0;
    int n_fail  = 0;

    exec_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_tag     (out_tag),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic base(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic ill);
        vecs.push_back('{op, a, b, 5'(vecs.size() + 1), res, ill, 1});
    endtask

    task automatic mop(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res);
        vecs.push_back('{op, a, b, 5'(vecs.size() + 1), (MDU ? res : 32'h0), !MDU, M_LAT});
    endtask

    task automatic idle(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Latency counts edges from the acceptance edge (=1) to the one after which out_valid is seen.
    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        int wait_n;
        bit busy_ok;
        wait_n  = 0;
        busy_ok = 1'b1;
        @(negedge clk);
        in_valid  = 1'b1;
        in_op     = v.op;
        in_a      = v.a;
        in_b      = v.b;
        in_tag    = v.tag;
        out_ready = 1'b1;
        while (!in_ready && wait_n < 100) begin
            @(negedge clk);
            wait_n++;
        end
        check($sformatf("v%0d_accept", idx), 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        check($sformatf("v%0d_op%02h_latency", idx, v.op), 32'(lat), 32'(v.lat));
        check($sformatf("v%0d_op%02h_result", idx, v.op), out_result, v.res);
        check($sformatf("v%0d_op%02h_tag", idx, v.op), 32'(out_tag), 32'(v.tag));
        check($sformatf("v%0d_op%02h_illegal", idx, v.op), 32'(out_illegal), 32'(v.ill));
        if (v.lat > 1) check($sformatf("v%0d_busy_not_ready", idx), 32'(busy_ok), 32'd1);
    endtask

    initial begin
        bit ok;
        bit seen;
        vec_t v;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_op = '0; in_a = '0; in_b = '0; in_tag = '0;

        base(OP_ADD,   32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0);
        base(OP_SRA,   32'h80000000, 32'h00000024, 32'hF8000000, 1'b0);
        base(5'h04,    32'hDEADBEEF, 32'h00001234, 32'h00000000, 1'b1);
        base(OP_SUB,   32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0);
        base(OP_SLT,   32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0);
        base(OP_SLTU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0);
        base(OP_SLL,   32'h00000001, 32'h0000003F, 32'h80000000, 1'b0);
        base(OP_SRL,   32'h80000000, 32'h00000004, 32'h08000000, 1'b0);
        base(OP_XOR,   32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0);
        base(OP_AND,   32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0);
        base(OP_OR,    32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0);
        base(OP_PASSA, 32'h12345678, 32'h9ABCDEF0, 32'h12345678, 1'b0);
        base(OP_PASSB, 32'h12345678, 32'h9ABCDEF0, 32'h9ABCDEF0, 1'b0);
        base(5'h05,    32'h00000001, 32'h00000001, 32'h00000000, 1'b1);
        base(5'h0E,    32'h00000001, 32'h00000001, 32'h00000000, 1'b1);
        base(5'h0F,    32'h00000001, 32'h00000001, 32'h00000000, 1'b1);
        base(5'h18,    32'h00000003, 32'h00000004, 32'h00000000, 1'b1);
        base(5'h1F,    32'h00000003, 32'h00000004, 32'h00000000, 1'b1);
        mop(OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
        mop(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        mop(OP_MUL,    32'h00000003, 32'h00000004, 32'h0000000C);
        mop(OP_MUL,    32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1);
        mop(OP_MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF);
        mop(OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        mop(OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000);
        mop(OP_DIVU,   32'h00000007, 32'h00000000, 32'hFFFFFFFF);
        mop(OP_REMU,   32'h00000007, 32'h00000000, 32'h00000007);
        mop(OP_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD);
        mop(OP_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF);
        mop(OP_DIV,    32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF);
        mop(OP_REM,    32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9);
        mop(OP_DIVU,   32'h00000064, 32'h00000007, 32'h0000000E);
        mop(OP_REMU,   32'h00000064, 32'h00000007, 32'h00000002);

        #1;
        check("reset_outputs", {27'h0, out_valid, out_illegal, in_ready, 2'b00}, 32'h0);
        check("reset_result", out_result, 32'h0);
        check("reset_tag", 32'(out_tag), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], i);
        end

        // Backpressure: result held for 5 cycles, then drained while a new op is accepted.
        idle(2);
        in_valid = 1'b1; in_op = OP_ADD; in_a = 32'd2; in_b = 32'd3; in_tag = 5'd9; out_ready = 1'b0;
        check("bp_accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_op = OP_SUB; in_a = 32'd10; in_b = 32'd4; in_tag = 5'd3;
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (!(out_valid && out_result == 32'd5 && out_tag == 5'd9 && !in_ready)) ok = 1'b0;
        end
        check("bp_hold_stable", 32'(ok), 32'd1);
        out_ready = 1'b1;
        #1;
        check("bp_ready_on_drain", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_new_valid", 32'(out_valid), 32'd1);
        check("bp_new_result", out_result, 32'd6);
        check("bp_new_tag", 32'(out_tag), 32'd3);

        // Flush drops a held result and wins over a simultaneous request.
        idle(2);
        in_valid = 1'b1; in_op = OP_ADD; in_a = 32'd1; in_b = 32'd1; in_tag = 5'd4; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("fl_held_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_op = OP_PASSA; in_a = 32'h55; out_ready = 1'b1;
        #1;
        check("fl_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        check("fl_dropped", {out_valid, out_result[30:0]}, 32'd0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("fl_no_accept", 32'(seen), 32'd0);

`ifdef EXEC_UNIT_MDU_EN
        // Flush at BUSY step 10: that result never appears.
        idle(1);
        in_valid = 1'b1; in_op = OP_DIV; in_a = 32'd100; in_b = 32'd7; in_tag = 5'd6;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("fl_busy_ready_after", 32'(in_ready), 32'd1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("fl_busy_no_result", 32'(seen), 32'd0);

        // Reset mid-BUSY, then a base op must complete in one cycle.
        idle(1);
        in_valid = 1'b1; in_op = OP_MUL; in_a = 32'd9; in_b = 32'd9; in_tag = 5'd2;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_busy_flags", {29'h0, out_valid, out_illegal, in_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        v = '{OP_ADD, 32'd40, 32'd2, 5'd17, 32'd42, 1'b0, 1};
        run_vec(v, 100);
`endif

        // Reset while a nonzero result is held: everything clears immediately.
        idle(1);
        in_valid = 1'b1; in_op = OP_ADD; in_a = 32'h10; in_b = 32'h20; in_tag = 5'h1F; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("rst_pre_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_async_flags", {29'h0, out_valid, out_illegal, in_ready}, 32'd0);
        check("rst_async_result", out_result, 32'd0);
        check("rst_async_tag", 32'(out_tag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_unit.md
# exec_unit

Parametrised, handshaked integer execute unit for the RV32 core, successor to the purely combinational ALU. It performs all base integer ALU operations with one registered cycle of latency. It also performs the RV32M multiply/divide/remainder operations through an iterative, fixed-latency datapath. It sits between decode/operand-read and writeback, decoupled on both sides by valid/ready handshakes.

## Interface
- `XLEN`, 32: operand and result width; power of two, ≥ 8.
- `TAG_W`, 5: width of the opaque tag carried from input to output (e.g. destination register).
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous abort of in-flight and pending work.
- `in_valid` input 1: operation request.
- `in_ready` output 1: unit accepts the request this cycle.
- `in_op` input 5: operation code; see Operation.
- `in_a`, `in_b` input XLEN: operands A and B.
- `in_tag` input TAG_W: tag.
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer accepts the result.
- `out_result` output XLEN: result.
- `out_tag` output TAG_W: tag of the request that produced the result.
- `out_illegal` output 1: the opcode was undefined; the result is 0.

## Operation
- Acceptance: a request is accepted on a rising edge where `in_valid && in_ready`.
- `in_ready` = state IDLE && !flush && (!out_valid || out_ready).
- Base ops, `in_op[4]=0`, computed on `in_op[3:0]`:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0110 SUB.
  - 0111 SLT (signed) and 1011 SLTU: result is 1 or 0, zero-extended.
  - 1000 SLL, 1001 SRL, 1010 SRA: shift amount is `in_b[$clog2(XLEN)-1:0]`.
  - 1100 pass A, 1101 pass B.
  - 0100, 0101, 1110, 1111: `out_illegal`=1, result 0.
- M ops, `in_op[4]=1`, selected by `in_op[2:0]`:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
  - `in_op[3]=1` is illegal.
- Arithmetic wraps modulo 2^XLEN. MUL returns the low XLEN bits; MULH* return the high XLEN bits of the 2·XLEN-bit product with the stated signedness.
- Divide by zero: DIV/DIVU return all ones; REM/REMU return A.
- Signed overflow (A = −2^(XLEN−1), B = −1): DIV returns A; REM returns 0.
- Special cases use the same latency as normal M ops.
- State machine:
  - IDLE: an accepted M op latches magnitudes, signs and tag → BUSY. An accepted base op loads the output register directly and stays in IDLE.
  - BUSY: one shift-add or restore-subtract step per cycle; the step counter runs XLEN−1 down to 0; at 0 → FIX.
  - FIX: sign correction and special-case override; loads the output register → IDLE.
- Output register: holds result, tag and illegal flag while `out_valid && !out_ready`. It is cleared when `out_ready` is sampled high and no new result loads in the same cycle.
- `flush`: the next state is IDLE and `out_valid` drops the next cycle; no result from before the flush is ever presented. `flush` takes priority over acceptance and over completion in the same cycle.
- Reset: asynchronous clear to IDLE at any time, including mid-iteration.

## Timing
- Reset values: `out_valid`=0, `in_ready`=0 while `rst_n` is low, `out_result`=0, `out_tag`=0, `out_illegal`=0, state IDLE, counter 0.
- Base op accepted at edge E: `out_valid`=1 after E, for one cycle of latency. Back-to-back throughput is 1 per cycle while `out_ready`=1.
- M op accepted at edge E: BUSY for XLEN cycles, then FIX for 1 cycle; `out_valid` rises after edge E+XLEN+1. That is XLEN+2 edges after acceptance, which is 34 for XLEN=32.
- `in_ready`=0 throughout BUSY and FIX.
- Backpressure: `out_valid`, `out_result` and `out_tag` are stable while `out_valid && !out_ready`.
- No combinational path from `in_*` to `out_*`. `in_ready` depends combinationally only on state, `out_valid`, `out_ready` and `flush`.

## Configuration
- `EXEC_UNIT_MDU_EN` defined: the M ops are implemented as described.
- `EXEC_UNIT_MDU_EN` undefined:
  - No iterative datapath and no BUSY/FIX states.
  - Every `in_op[4]=1` is treated as illegal: result 0, `out_illegal`=1, single-cycle latency.

## Structure
- Package `exec_pkg` holds:
  - the 5-bit opcode localparams;
  - the state enum (IDLE, BUSY, FIX);
  - the special-result constants (all ones, most-negative value).
- Sub-module `exec_mdu_iter`, instantiated only under `EXEC_UNIT_MDU_EN`, contains the shared XLEN-step shift-add multiplier / restoring divider datapath and its step counter. The top level holds the handshake logic, the base ALU, and the output register.

## Test plan
- ADD 0x7FFFFFFF + 1 → 0x80000000, 1 cycle; SRA 0x80000000 by B=0x24 (amount 4) → 0xF8000000; opcode 0x04 → result 0, `out_illegal`=1.
- MULH 0xFFFFFFFF × 0xFFFFFFFF → 0x00000000; MULHU on the same operands → 0xFFFFFFFE; `out_valid` rises exactly 34 edges after acceptance, with `in_ready`=0 meanwhile.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, REM → 0; DIVU 7 / 0 → 0xFFFFFFFF, REMU 7 / 0 → 7; DIV −7 / 2 → 0xFFFFFFFD, REM → 0xFFFFFFFF.
- Hold `out_ready`=0 for 5 cycles after a result: result and tag stay stable and `in_ready`=0. Then raise `out_ready` with a new `in_valid`: the old result drains and the new op is accepted on the same edge.
- `flush` asserted at BUSY step 10: `out_valid` never rises for that op, and `in_ready`=1 the cycle after `flush` deasserts. `rst_n` pulsed low mid-BUSY: all outputs are 0 immediately.
- Build without `EXEC_UNIT_MDU_EN`: MUL 3×4 → result 0, `out_illegal`=1, 1-cycle latency.
